// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults, pointer width helper and occupancy states
package fifo_pkg;
  localparam int ADDRSIZE_DEF = 4;
  function automatic int ptr_w(input int addrsize);
    return addrsize + 1;
  endfunction
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping binary pointer with enable, exposing its next value
module fifo_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] ptr,
  output logic [W-1:0] ptr_nxt
);
  assign ptr_nxt = ptr + W'(en);
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FWFT FIFO controller driving an external memory
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = ADDRSIZE_DEF,
  parameter int AFULL_LVL = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic                rinc,
  input  logic                clr_err,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                wclken,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   count,
  output logic                wovf,
  output logic                rudf
);
  localparam int PW    = ptr_w(ADDRSIZE);
  localparam int DEPTH = 1 << ADDRSIZE;
  occ_t          state, state_nxt;
  logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt, cnt_nxt;
  logic          wa, ra;
  assign wa = winc & ~wfull & ~wrst;
  assign ra = rinc & ~rempty & ~wrst;
  fifo_ptr #(.W(PW)) u_wptr (.clk(wclk), .rst(wrst), .en(wa), .ptr(wptr), .ptr_nxt(wptr_nxt));
  fifo_ptr #(.W(PW)) u_rptr (.clk(wclk), .rst(wrst), .en(ra), .ptr(rptr), .ptr_nxt(rptr_nxt));
  assign cnt_nxt = wptr_nxt - rptr_nxt;
  // A simultaneous push/pop at a boundary is a legal transfer, so it never flags an error
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      state        <= EMPTY;
      count        <= '0;
      walmost_full <= 1'b0;
      wovf         <= 1'b0;
      rudf         <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= cnt_nxt;
      walmost_full <= cnt_nxt >= PW'(AFULL_LVL);
      wovf         <= (winc & wfull & ~rinc) | (wovf & ~clr_err);
      rudf         <= (rinc & rempty & ~winc) | (rudf & ~clr_err);
    end
  always_comb
    state_nxt = (cnt_nxt == '0) ? EMPTY : (cnt_nxt == PW'(DEPTH)) ? FULL : PARTIAL;
  always_comb begin
    rempty = state == EMPTY;
    wfull  = state == FULL;
    wclken = wa;
    waddr  = wptr[ADDRSIZE-1:0];
    raddr  = rptr[ADDRSIZE-1:0];
  end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed checks of the FIFO controller with a bench-side memory
module tb_sync_fifo_ctrl;
  logic       wclk = 1'b0, wrst = 1'b1, winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
  logic [3:0] waddr, raddr;
  logic       wclken, wfull, rempty, walmost_full, wovf, rudf;
  logic [4:0] count;
  int         wdata = 0;
  int         mem [16];
  int         checks = 0, failures = 0;

  sync_fifo_ctrl dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .rinc(rinc), .clr_err(clr_err),
    .waddr(waddr), .raddr(raddr), .wclken(wclken), .wfull(wfull), .rempty(rempty),
    .walmost_full(walmost_full), .count(count), .wovf(wovf), .rudf(rudf)
  );

  always #5 wclk = ~wclk;
  always @(posedge wclk) if (wclken) mem[waddr] <= wdata;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_count", int'(count), 0);
    check("rst_rempty", int'(rempty), 1);
    check("rst_wfull", int'(wfull), 0);
    check("rst_afull", int'(walmost_full), 0);
    check("rst_err", int'({wovf, rudf}), 0);
    check("rst_wclken", int'(wclken), 0);
    #9 wrst = 1'b0;
    // 16 back-to-back writes
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wdata = 100 + i;
      if (i == 16) check("wclken_16", int'(wclken), 1);
      cyc();
      if (i == 1) check("rempty_1w", int'(rempty), 0);
      if (i == 13) check("afull_13", int'(walmost_full), 0);
      if (i == 14) check("afull_14", int'(walmost_full), 1);
      if (i == 15) check("wfull_15", int'(wfull), 0);
    end
    check("wfull_16", int'(wfull), 1);
    check("count_16", int'(count), 16);
    #1 check("wclken_17", int'(wclken), 0);
    cyc();
    check("wovf_17", int'(wovf), 1);
    check("count_17", int'(count), 16);
    // drain in write order
    winc = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("data_%0d", i), mem[raddr], 100 + i);
      rinc = 1'b1;
      cyc();
      if (i == 1) check("pop1", int'({count, wfull}), 15 << 1);
    end
    check("drain_rempty", int'(rempty), 1);
    check("drain_count", int'(count), 0);
    cyc();
    check("rudf_set", int'(rudf), 1);
    check("rudf_count", int'(count), 0);
    rinc = 1'b0; clr_err = 1'b1;
    cyc();
    check("clr_both", int'({wovf, rudf}), 0);
    clr_err = 1'b0;
    // push+pop while empty: only write accepted, no underflow
    winc = 1'b1; rinc = 1'b1; wdata = 7;
    cyc();
    check("empty_both_count", int'(count), 1);
    check("empty_both_rudf", int'(rudf), 0);
    rinc = 1'b0;
    repeat (4) cyc();
    check("count_5", int'(count), 5);
    // steady push+pop with pointer wrap
    rinc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      check($sformatf("steady_%0d", i), int'({count, rempty, wfull, walmost_full}), 5 << 3);
    end
    check("waddr_wrap", int'(waddr), 13);
    check("raddr_wrap", int'(raddr), 8);
    rinc = 1'b0;
    repeat (11) cyc();
    check("refill_wfull", int'(wfull), 1);
    check("refill_count", int'(count), 16);
    // push+pop while full: only read accepted, no overflow
    rinc = 1'b1;
    cyc();
    check("full_both_count", int'(count), 15);
    check("full_both_wovf", int'(wovf), 0);
    rinc = 1'b0;
    cyc();
    check("full_again", int'(wfull), 1);
    cyc();
    check("wovf_full", int'(wovf), 1);
    clr_err = 1'b1;
    cyc();
    check("clr_vs_set", int'(wovf), 1);
    winc = 1'b0;
    cyc();
    check("clr_alone", int'(wovf), 0);
    clr_err = 1'b0;
    // async reset at count 9
    rinc = 1'b1;
    repeat (7) cyc();
    rinc = 1'b0;
    check("count_9", int'(count), 9);
    @(negedge wclk);
    wrst = 1'b1;
    #1;
    check("arst_rempty", int'(rempty), 1);
    check("arst_count", int'(count), 0);
    check("arst_ptrs", int'({waddr, raddr}), 0);
    #2 wrst = 1'b0;
    winc = 1'b1; wdata = 55;
    cyc();
    winc = 1'b0;
    check("post_rst_rempty", int'(rempty), 0);
    check("post_rst_count", int'(count), 1);
    check("post_rst_data", mem[raddr], 55);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
